// File: rtl/microtan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : microtan_pkg                                             |
// | Purpose : Shared video-RAM sizing constants and the arbiter's      |
// |           fetch-state encoding.                                    |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package microtan_pkg;

  localparam int VRAM_ADDR_W   = 13;  // 8K words
  localparam int VRAM_DATA_W   = 9;   // bit 8 = graphics flag, 7:0 = data
  localparam int VRAM_LINE_LEN = 32;  // characters fetched per row

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } vram_state_e;

endpackage : microtan_pkg
`default_nettype wire

// File: rtl/vram_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : vram_line_buffer                                         |
// | Purpose : Double-banked row buffer. The fetcher writes the back    |
// |           bank while scanout reads the front bank.                 |
// | Rev     : 1.0  initial release                                     |
// | Ports   : clk, reset_n  - clock, async active-low reset            |
// |           swap          - exchange banks at the next edge          |
// |           wr_en/wr_idx/wr_data - write port into the back bank     |
// |           rd_idx/rd_data       - registered read of the front bank |
// +--------------------------------------------------------------------+
module vram_line_buffer
  import microtan_pkg::*;
#(
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int LINE_LEN = VRAM_LINE_LEN
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        swap,
  input  logic                        wr_en,
  input  logic [$clog2(LINE_LEN)-1:0] wr_idx,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [$clog2(LINE_LEN)-1:0] rd_idx,
  output logic [DATA_W-1:0]           rd_data
);

  logic              front_q, front_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_q [2][LINE_LEN];

  always_comb begin
    front_d   = swap ? ~front_q : front_q;
    rd_data_d = mem_q[front_q][rd_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      front_q   <= front_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage has no reset: buffer contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[~front_q][wr_idx] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule : vram_line_buffer
`default_nettype wire

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : vram_arbiter                                             |
// | Purpose : Shares one synchronous single-port VRAM between the CPU  |
// |           (one reserved slot per cpu_clken) and a row fetcher that |
// |           fills a double-banked line buffer for scanout.           |
// | Rev     : 1.0  initial release                                     |
// | Ports   : clk, reset_n            - clock, async active-low reset  |
// |           cpu_clken/req/we/addr/wdata, cpu_rdata/ack - CPU access  |
// |           vid_start/base, vid_swap, vid_rd_addr/data - video side  |
// |           vid_busy/done/overrun   - fetch status                   |
// |           ram_addr/we/wdata/rdata - VRAM port (1-cycle read)       |
// +--------------------------------------------------------------------+
module vram_arbiter
  import microtan_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int LINE_LEN = VRAM_LINE_LEN
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cpu_clken,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic [7:0]                  cpu_rdata,
  output logic                        cpu_ack,
  input  logic                        vid_start,
  input  logic [ADDR_W-1:0]           vid_base,
  input  logic                        vid_swap,
  input  logic [$clog2(LINE_LEN)-1:0] vid_rd_addr,
  output logic [DATA_W-1:0]           vid_rd_data,
  output logic                        vid_busy,
  output logic                        vid_done,
  output logic                        vid_overrun,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic                        ram_we,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata
);

  localparam int               IDX_W    = $clog2(LINE_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  // CPU side
  logic              slot_q, slot_d;
  logic              cpu_req_q, cpu_req_d;
  logic              cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
  logic              cpu_ret_q, cpu_ret_d;       // slot access whose data returns now
  logic              cpu_ret_we_q, cpu_ret_we_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;

  // Video side
  vram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              issue_q, issue_d;           // video read returns this cycle
  logic [IDX_W-1:0]  issue_idx_q, issue_idx_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              busy;
  logic              buf_wr_en;

  assign busy = (state_q != IDLE);

  always_comb begin
    slot_d       = cpu_clken;
    cpu_req_d    = cpu_req_q;
    cpu_we_d     = cpu_we_q;
    cpu_addr_d   = cpu_addr_q;
    cpu_wdata_d  = cpu_wdata_q;
    if (cpu_clken) begin
      cpu_req_d   = cpu_req;
      cpu_we_d    = cpu_we;
      cpu_addr_d  = cpu_addr;
      cpu_wdata_d = cpu_wdata;
    end
    cpu_ret_d    = slot_q & cpu_req_q;
    cpu_ret_we_d = cpu_we_q;
    cpu_ack_d    = cpu_ret_q;
    cpu_rdata_d  = (cpu_ret_q && !cpu_ret_we_q) ? ram_rdata[7:0] : cpu_rdata_q;
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    issue_d     = 1'b0;
    issue_idx_d = idx_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (!slot_q) begin
          issue_d = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      // The last word lands in the buffer at the end of this cycle.
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase

    if (vid_swap && busy) begin
      state_d   = IDLE;
      overrun_d = 1'b1;
      done_d    = 1'b0;
      issue_d   = 1'b0;
    end

    // Evaluated after the swap so a simultaneous swap+start fetches into the
    // freshly exposed back bank.
    if (vid_start) begin
      state_d = FETCH;
      base_d  = vid_base;
      idx_d   = '0;
      issue_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // A start or swap discards the word returning in the same cycle.
  assign buf_wr_en = issue_q & ~vid_start & ~vid_swap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q       <= 1'b0;
      cpu_req_q    <= 1'b0;
      cpu_we_q     <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_wdata_q  <= '0;
      cpu_ret_q    <= 1'b0;
      cpu_ret_we_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      state_q      <= IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      issue_q      <= 1'b0;
      issue_idx_q  <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      cpu_req_q    <= cpu_req_d;
      cpu_we_q     <= cpu_we_d;
      cpu_addr_q   <= cpu_addr_d;
      cpu_wdata_q  <= cpu_wdata_d;
      cpu_ret_q    <= cpu_ret_d;
      cpu_ret_we_q <= cpu_ret_we_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      issue_q      <= issue_d;
      issue_idx_q  <= issue_idx_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    ram_addr = '0;
    if (slot_q) begin
      ram_addr = cpu_addr_q;
    end else if (state_q == FETCH) begin
      ram_addr = base_q + ADDR_W'(idx_q);  // wraps modulo 2^ADDR_W
    end
  end

  assign ram_we      = slot_q & cpu_req_q & cpu_we_q;
  assign ram_wdata   = cpu_wdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign vid_busy    = busy;
  assign vid_done    = done_q;
  assign vid_overrun = overrun_q;

  vram_line_buffer #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN)
  ) u_line_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .swap    (vid_swap),
    .wr_en   (buf_wr_en),
    .wr_idx  (issue_idx_q),
    .wr_data (ram_rdata),
    .rd_idx  (vid_rd_addr),
    .rd_data (vid_rd_data)
  );

endmodule : vram_arbiter
`default_nettype wire
